fetch_controller: RTL and testbench

Instruction-fetch sequencer for the single-cycle/pipelined MIPS core. It owns the program counter and drives the combinational instruction memory's Address input. It captures the returned Instruction into an IF/ID output register with a valid/ready handshake toward decode. It handles start, redirect (branch/jump), backpressure, self-jump halt detection, and address faults.

---
 rtl/fetch_controller_pkg.sv | 23 ++
 rtl/fetch_controller.sv | 117 +++++++++++
 tb/tb_fetch_controller.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_controller_pkg.sv
// Shared fetch definitions: FSM state encoding, jump opcode field and self-jump test.
`ifndef FETCH_CONTROLLER_PKG_SV
`define FETCH_CONTROLLER_PKG_SV
package fetch_controller_pkg;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_RUN   = 2'd1,
    FS_HALT  = 2'd2,
    FS_FAULT = 2'd3
  } fetch_state_e;

  localparam logic [5:0] OP_J        = 6'h02;
  localparam int         OP_FIELD_HI = 31;
  localparam int         OP_FIELD_LO = 26;

  // A J instruction whose target word index equals its own address spins forever.
  function automatic logic is_self_jump(input logic [31:0] instr, input logic [31:0] pc);
    return (instr[OP_FIELD_HI:OP_FIELD_LO] == OP_J) && (instr[25:0] == pc[27:2]);
  endfunction

endpackage
`endif

// File: rtl/fetch_controller.sv
// Fetch sequencer: owns PC, fills IF/ID; first OutValid two edges after Start, then one per cycle.
// Holds PC and IF/ID while OutValid && !OutReady; Redirect flushes IF/ID regardless of OutReady.
module fetch_controller
  import fetch_controller_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  output logic [31:0] Address,
  input  logic [31:0] Instruction,
  output logic        OutValid,
  input  logic        OutReady,
  output logic [31:0] OutInstr,
  output logic [31:0] OutPC,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  output logic        Halted,
  output logic        Fault,
  output logic [31:0] FetchCount
);

  localparam logic [32:0] IMEM_BYTES = 33'(IMEM_WORDS) << 2;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         out_valid_q, out_valid_d;
  logic [31:0]  out_instr_q, out_instr_d;
  logic [31:0]  out_pc_q, out_pc_d;
  logic [31:0]  fetch_count_q, fetch_count_d;
  logic         halted_q, halted_d;
  logic         fault_q, fault_d;

  logic [32:0]  pc_inc;
  logic         redirect_bad;
  logic         self_jump;
  logic         load;

  always_comb begin
    // 33-bit increment so the bound check sees overrun before any 32-bit wrap.
    pc_inc       = {1'b0, pc_q} + 33'd4;
    redirect_bad = (RedirectPC[1:0] != 2'b00) || ({1'b0, RedirectPC} >= IMEM_BYTES);
    self_jump    = is_self_jump(Instruction, pc_q);
    load         = (state_q == FS_RUN) && !Redirect && (!out_valid_q || OutReady);

    state_d       = state_q;
    pc_d          = pc_q;
    out_valid_d   = out_valid_q;
    out_instr_d   = out_instr_q;
    out_pc_d      = out_pc_q;
    fetch_count_d = fetch_count_q;

    unique case (state_q)
      FS_IDLE: begin
        out_valid_d = 1'b0;
        if (Start) state_d = FS_RUN;
      end
      FS_RUN: begin
        if (Redirect) begin
          out_valid_d = 1'b0;
          if (redirect_bad) state_d = FS_FAULT;
          else              pc_d    = RedirectPC;
        end else if (load) begin
          out_valid_d = 1'b1;
          out_instr_d = Instruction;
          out_pc_d    = pc_q;
          if (fetch_count_q != 32'hFFFF_FFFF) fetch_count_d = fetch_count_q + 32'd1;
          if (self_jump)                  state_d = FS_HALT;
          else if (pc_inc >= IMEM_BYTES)  state_d = FS_FAULT;
          else                            pc_d    = pc_inc[31:0];
        end
      end
      FS_HALT: begin
        if (out_valid_q && OutReady) out_valid_d = 1'b0;
      end
      FS_FAULT: begin
        out_valid_d = 1'b0;
      end
    endcase

    halted_d = (state_d == FS_HALT);
    fault_d  = (state_d == FS_FAULT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= FS_IDLE;
      pc_q          <= RESET_PC;
      out_valid_q   <= 1'b0;
      out_instr_q   <= 32'h0;
      out_pc_q      <= 32'h0;
      fetch_count_q <= 32'h0;
      halted_q      <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      out_valid_q   <= out_valid_d;
      out_instr_q   <= out_instr_d;
      out_pc_q      <= out_pc_d;
      fetch_count_q <= fetch_count_d;
      halted_q      <= halted_d;
      fault_q       <= fault_d;
    end
  end

  assign Address    = pc_q;
  assign OutValid   = out_valid_q;
  assign OutInstr   = out_instr_q;
  assign OutPC      = out_pc_q;
  assign FetchCount = fetch_count_q;
  assign Halted     = halted_q;
  assign Fault      = fault_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Directed and randomized checks of fetch_controller against a transaction-level reference model.
module tb_fetch_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b, Start, OutReady, Redirect;
  logic [31:0] RedirectPC;
  logic        use4;

  logic [31:0] addr_a, instr_a, oinstr_a, opc_a, cnt_a;
  logic        vld_a, halt_a, fault_a;
  logic [31:0] addr_b, instr_b, oinstr_b, opc_b, cnt_b;
  logic        vld_b, halt_b, fault_b;

  logic [31:0] mem [256];

  function automatic logic [31:0] imem(input logic [31:0] a);
    if (a[31:10] != 22'd0) return 32'h0;
    return mem[a[9:2]];
  endfunction

  always_comb instr_a = imem(addr_a);
  always_comb instr_b = imem(addr_b);

  fetch_controller #(.RESET_PC(32'h0), .IMEM_WORDS(256)) dut_a (
    .clk(clk), .reset(rst_a), .Start(Start), .Address(addr_a), .Instruction(instr_a),
    .OutValid(vld_a), .OutReady(OutReady), .OutInstr(oinstr_a), .OutPC(opc_a),
    .Redirect(Redirect), .RedirectPC(RedirectPC), .Halted(halt_a), .Fault(fault_a),
    .FetchCount(cnt_a));

  fetch_controller #(.RESET_PC(32'h0), .IMEM_WORDS(4)) dut_b (
    .clk(clk), .reset(rst_b), .Start(Start), .Address(addr_b), .Instruction(instr_b),
    .OutValid(vld_b), .OutReady(OutReady), .OutInstr(oinstr_b), .OutPC(opc_b),
    .Redirect(Redirect), .RedirectPC(RedirectPC), .Halted(halt_b), .Fault(fault_b),
    .FetchCount(cnt_b));

  logic [31:0] o_addr, o_instr, o_pc, o_cnt;
  logic        o_vld, o_halt, o_fault;
  always_comb begin
    o_addr  = use4 ? addr_b   : addr_a;
    o_instr = use4 ? oinstr_b : oinstr_a;
    o_pc    = use4 ? opc_b    : opc_a;
    o_cnt   = use4 ? cnt_b    : cnt_a;
    o_vld   = use4 ? vld_b    : vld_a;
    o_halt  = use4 ? halt_b   : halt_a;
    o_fault = use4 ? fault_b  : fault_a;
  end

  // Reference model: a mode, the next fetch address, and a one-deep IF/ID slot.
  typedef enum {M_IDLE, M_RUN, M_HALT, M_FAULT} mode_t;
  mode_t       m_st;
  int          m_words;
  logic [31:0] m_pc, m_instr, m_opc, m_cnt;
  bit          m_vld;
  logic [31:0] acc_pc[$];
  logic [31:0] acc_in[$];

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_st = M_IDLE; m_pc = 32'h0; m_vld = 0; m_instr = 32'h0; m_opc = 32'h0; m_cnt = 32'h0;
  endtask

  task automatic log_accept();
    acc_pc.push_back(m_opc);
    acc_in.push_back(m_instr);
  endtask

  task automatic model_step();
    logic [31:0] w;
    case (m_st)
      M_IDLE: if (Start) m_st = M_RUN;
      M_RUN: begin
        if (Redirect) begin
          m_vld = 0;
          if (RedirectPC[1:0] != 2'b00 || longint'(RedirectPC) >= longint'(m_words) * 4)
            m_st = M_FAULT;
          else
            m_pc = RedirectPC;
        end else if (!m_vld || OutReady) begin
          if (m_vld) log_accept();
          w = imem(m_pc);
          m_instr = w; m_opc = m_pc; m_vld = 1;
          if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
          if (w[31:26] == 6'h02 && w[25:0] == m_pc[27:2]) m_st = M_HALT;
          else if (longint'(m_pc) + 4 >= longint'(m_words) * 4) m_st = M_FAULT;
          else m_pc = m_pc + 4;
        end
      end
      M_HALT: if (m_vld && OutReady) begin log_accept(); m_vld = 0; end
      M_FAULT: begin if (m_vld && OutReady) log_accept(); m_vld = 0; end
    endcase
  endtask

  task automatic check_all(input string ph);
    chk({ph, ".addr"},  o_addr,  m_pc);
    chk({ph, ".vld"},   o_vld,   m_vld);
    chk({ph, ".instr"}, o_instr, m_instr);
    chk({ph, ".opc"},   o_pc,    m_opc);
    chk({ph, ".halt"},  o_halt,  m_st == M_HALT);
    chk({ph, ".fault"}, o_fault, m_st == M_FAULT);
    chk({ph, ".cnt"},   o_cnt,   m_cnt);
  endtask

  task automatic tick(input string ph);
    model_step();
    @(posedge clk);
    #1;
    check_all(ph);
  endtask

  task automatic do_reset();
    if (use4) rst_b = 1'b1; else rst_a = 1'b1;
    Start = 0; Redirect = 0;
    model_reset();
    @(posedge clk);
    #1;
    if (use4) rst_b = 1'b0; else rst_a = 1'b0;
    check_all("rst");
  endtask

  task automatic start_run();
    Start = 1;
    tick("start");
    Start = 0;
  endtask

  task automatic run_until(input logic [31:0] pc, input string tag);
    bit hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      tick(tag);
      hit = o_vld && (o_pc == pc);
    end
    chk({tag, ".reached"}, hit, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w, rp;
    int r;
    mem[0]  = 32'h20043039; mem[1]  = 32'h20050005; mem[2]  = 32'h00853020;
    mem[3]  = 32'h00A63822; mem[4]  = 32'h8C080000; mem[5]  = 32'hAC080004;
    mem[6]  = 32'h00C44020; mem[7]  = 32'h10A00001; mem[8]  = 32'h00000000;
    mem[9]  = 32'h3C091234; mem[10] = 32'h35290ABC; mem[11] = 32'h0800000B;
    for (int i = 12; i < 256; i++) begin
      w = $urandom;
      if (w[31:26] == 6'h02) w[31:26] = 6'h23;
      mem[i] = w;
    end

    use4 = 0; m_words = 256;
    rst_a = 1; rst_b = 1; Start = 0; OutReady = 0; Redirect = 0; RedirectPC = 32'h0;
    model_reset();
    #2;
    check_all("por");
    @(posedge clk);
    #1;
    rst_a = 0;
    check_all("por_rel");

    // Straight-line program ending in a self-jump.
    start_run();
    OutReady = 1;
    acc_pc.delete(); acc_in.delete();
    repeat (16) tick("prog");
    chk("prog.n_acc", acc_pc.size(), 12);
    for (int i = 0; i < 12; i++)
      chk($sformatf("prog.pc%0d", i), (acc_pc.size() > i) ? acc_pc[i] : 32'hX, 32'(i * 4));
    chk("prog.first", (acc_in.size() > 0) ? acc_in[0] : 32'hX, 32'h20043039);
    chk("prog.last", (acc_in.size() > 11) ? acc_in[11] : 32'hX, 32'h0800000B);
    chk("prog.cnt", o_cnt, 32'd12);
    chk("prog.halt", o_halt, 1);
    chk("prog.vld", o_vld, 0);
    chk("prog.addr", o_addr, 32'h2C);
    Start = 1; Redirect = 1; RedirectPC = 32'h8;
    tick("halt_ign");
    Start = 0; Redirect = 0;
    chk("halt_ign.addr", o_addr, 32'h2C);

    // Backpressure at OutPC=0x8.
    do_reset();
    start_run();
    OutReady = 1;
    run_until(32'h8, "bp");
    OutReady = 0;
    repeat (3) tick("bp_hold");
    chk("bp.opc", o_pc, 32'h8);
    chk("bp.addr", o_addr, 32'hC);
    chk("bp.cnt", o_cnt, 32'd3);
    OutReady = 1;
    tick("bp_rel");
    chk("bp_rel.opc", o_pc, 32'hC);

    // Redirect beats backpressure.
    run_until(32'h10, "redir");
    OutReady = 0; Redirect = 1; RedirectPC = 32'h18;
    tick("redir1");
    Redirect = 0;
    chk("redir.vld", o_vld, 0);
    chk("redir.addr", o_addr, 32'h18);
    OutReady = 1;
    tick("redir2");
    chk("redir.opc", o_pc, 32'h18);
    chk("redir.instr", o_instr, 32'h00C44020);

    // Misaligned and out-of-range redirect targets.
    Redirect = 1; RedirectPC = 32'h1A;
    tick("mis");
    Redirect = 0;
    chk("mis.fault", o_fault, 1);
    chk("mis.vld", o_vld, 0);
    do_reset();
    start_run();
    tick("oor0");
    Redirect = 1; RedirectPC = 32'h400;
    tick("oor");
    Redirect = 0;
    chk("oor.fault", o_fault, 1);

    // Sequential overrun on a four-word memory.
    rst_a = 1;
    use4 = 1; m_words = 4;
    do_reset();
    start_run();
    acc_pc.delete(); acc_in.delete();
    repeat (8) tick("ovr");
    chk("ovr.n_acc", acc_pc.size(), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("ovr.pc%0d", i), (acc_pc.size() > i) ? acc_pc[i] : 32'hX, 32'(i * 4));
    chk("ovr.fault", o_fault, 1);
    chk("ovr.addr", o_addr, 32'hC);
    rst_b = 1;
    use4 = 0; m_words = 256;
    do_reset();

    // Asynchronous reset between edges.
    start_run();
    run_until(32'h14, "async");
    #3;
    rst_a = 1;
    #1;
    model_reset();
    check_all("async_rst");
    chk("async.vld", o_vld, 0);
    chk("async.cnt", o_cnt, 32'd0);
    @(posedge clk);
    #1;
    rst_a = 0;
    repeat (3) tick("async_idle");
    chk("async.addr", o_addr, 32'h0);

    // Randomized episodes.
    for (int ep = 0; ep < 6; ep++) begin
      do_reset();
      start_run();
      for (int c = 0; c < 80; c++) begin
        OutReady = ($urandom_range(0, 9) < 7);
        Redirect = ($urandom_range(0, 9) == 0);
        Start    = ($urandom_range(0, 19) == 0);
        r  = $urandom_range(0, 15);
        rp = 32'($urandom_range(0, 255)) << 2;
        if (r == 0) rp[1:0] = 2'($urandom_range(1, 3));
        else if (r == 1) rp = rp + 32'h400;
        RedirectPC = rp;
        tick("rand");
      end
      Start = 0; Redirect = 0;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
